// File: rtl/stopwatch_mux.sv
// Stopwatch with BCD count, multiplexed 4-digit seven-segment display and countdown mode.
// Define STOPWATCH_LAP_EN to build the lap-hold (display freeze) feature.
module stopwatch_mux #(
  parameter int TICK_DIV = 1000000,
  parameter int SCAN_DIV = 100000,
  parameter int SEC_MAX  = 59
) (
  input  logic       clk,
  input  logic       reset_ni,
  input  logic       start_i,
  input  logic       clear_i,
  input  logic       lap_i,
  input  logic       down_i,
  input  logic [6:0] load_sec_i,
  output logic [6:0] seven_seg_o,
  output logic       dp_o,
  output logic [3:0] anodes_o,
  output logic       running_o,
  output logic       expired_o,
  output logic       lap_active_o
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] DIV_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    SM_T      = 4'(SEC_MAX / 10);
  localparam logic [3:0]    SM_O      = 4'(SEC_MAX % 10);
  localparam logic [6:0]    SEC_CAP   = 7'(SEC_MAX);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  state_t          state;
  logic            mode;          // 1 = countdown
  logic [TW-1:0]   div;
  logic [3:0][3:0] cnt;           // [3]=sec tens .. [0]=centisecond ones
  logic [3:0][3:0] disp;
  logic [3:0][3:0] up_n, dn_n, ld_cnt;
  logic [2:0]      st_s, cl_s;    // two sync stages plus previous-value flop
  logic            st_edge, clr_edge, tick, exp_step;
  logic [6:0]      ld_sec;
  logic [SW-1:0]   scan_cnt;
  logic [1:0]      sel;

  assign st_edge  = st_s[1] & ~st_s[2];
  assign clr_edge = cl_s[1] & ~cl_s[2];
  assign tick     = (state == RUN) && (div == DIV_LAST);
  assign exp_step = tick && mode && (dn_n == '0);
  assign ld_sec   = (load_sec_i > SEC_CAP) ? SEC_CAP : load_sec_i;
  assign ld_cnt   = {4'(ld_sec / 7'd10), 4'(ld_sec % 7'd10), 4'd0, 4'd0};

  always_comb begin
    up_n = cnt;
    if (cnt[0] != 4'd9) up_n[0] = cnt[0] + 4'd1;
    else begin
      up_n[0] = 4'd0;
      if (cnt[1] != 4'd9) up_n[1] = cnt[1] + 4'd1;
      else begin
        up_n[1] = 4'd0;
        if (cnt[3] == SM_T && cnt[2] == SM_O) begin
          up_n[3] = 4'd0;
          up_n[2] = 4'd0;
        end else if (cnt[2] != 4'd9) up_n[2] = cnt[2] + 4'd1;
        else begin
          up_n[2] = 4'd0;
          up_n[3] = cnt[3] + 4'd1;
        end
      end
    end
  end

  // Never stepped from 00.00: reaching zero always leaves RUN.
  always_comb begin
    dn_n = cnt;
    if (cnt[0] != 4'd0) dn_n[0] = cnt[0] - 4'd1;
    else begin
      dn_n[0] = 4'd9;
      if (cnt[1] != 4'd0) dn_n[1] = cnt[1] - 4'd1;
      else begin
        dn_n[1] = 4'd9;
        if (cnt[2] != 4'd0) dn_n[2] = cnt[2] - 4'd1;
        else begin
          dn_n[2] = 4'd9;
          dn_n[3] = cnt[3] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      st_s      <= '0;
      cl_s      <= '0;
      state     <= IDLE;
      mode      <= 1'b0;
      div       <= '0;
      cnt       <= '0;
      running_o <= 1'b0;
      expired_o <= 1'b0;
    end else begin
      st_s      <= {st_s[1:0], start_i};
      cl_s      <= {cl_s[1:0], clear_i};
      expired_o <= 1'b0;
      if (state == IDLE) mode <= down_i;
      if (clr_edge) begin
        state     <= IDLE;
        div       <= '0;
        cnt       <= down_i ? ld_cnt : '0;
        running_o <= 1'b0;
      end else begin
        case (state)
          IDLE: if (st_edge) begin
            if (down_i && cnt == '0) begin
              state     <= EXPIRED;
              expired_o <= 1'b1;
            end else begin
              state     <= RUN;
              running_o <= 1'b1;
            end
          end
          RUN: if (st_edge) begin
            state     <= PAUSE;
            running_o <= 1'b0;
          end
          PAUSE: if (st_edge) begin
            state     <= RUN;
            running_o <= 1'b1;
          end
          EXPIRED: ;
        endcase
        // Divider keeps counting on the pause edge itself; expiry overrides a pause.
        if (state == RUN) begin
          if (tick) begin
            div <= '0;
            cnt <= mode ? dn_n : up_n;
            if (exp_step) begin
              state     <= EXPIRED;
              expired_o <= 1'b1;
              running_o <= 1'b0;
            end
          end else begin
            div <= div + TW'(1);
          end
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [2:0]      lp_s;
  logic            lap_hold;
  logic [3:0][3:0] lap_d;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      lp_s     <= '0;
      lap_hold <= 1'b0;
      lap_d    <= '0;
    end else begin
      lp_s <= {lp_s[1:0], lap_i};
      if (clr_edge || exp_step) lap_hold <= 1'b0;
      else if (state == RUN && lp_s[1] && !lp_s[2]) begin
        lap_hold <= ~lap_hold;
        if (!lap_hold) lap_d <= cnt;
      end
    end
  end

  assign lap_active_o = lap_hold;
  assign disp         = lap_hold ? lap_d : cnt;
`else
  logic unused_lap;
  assign unused_lap   = lap_i;
  assign lap_active_o = 1'b0;
  assign disp         = cnt;
`endif

  // Segments, dp and anodes all come from the same sel sample, so they never disagree.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      scan_cnt    <= '0;
      sel         <= 2'd0;
      anodes_o    <= 4'b1110;
      seven_seg_o <= 7'b1000000;
      dp_o        <= 1'b1;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        sel      <= sel + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      anodes_o    <= ~(4'b0001 << sel);
      seven_seg_o <= seg7(disp[sel]);
      dp_o        <= (sel != 2'd2);
    end
  end

endmodule

// File: tb/tb_stopwatch_mux.sv
// Bench for stopwatch_mux: directed scenario steps with randomized run lengths,
// expected counts derived from elapsed run cycles / TICK_DIV.
module tb_stopwatch_mux;
  localparam int TD = 4;
  localparam int SD = 3;

  logic       clk = 0, rst_n = 0;
  logic       st = 0, cl = 0, lp = 0, dn = 0, st2 = 0;
  logic [6:0] ld = '0;
  logic [6:0] seg1, seg2;
  logic       dp1, dp2, run1, run2, exp1, exp2, lap1, lap2;
  logic [3:0] an1, an2;

  int cyc = 0, total = 0, bad = 0;
  int exp_cnt = 0, last_exp = -1, exp2_cnt = 0;

  stopwatch_mux #(.TICK_DIV(TD), .SCAN_DIV(SD), .SEC_MAX(59)) dut (
    .clk(clk), .reset_ni(rst_n), .start_i(st), .clear_i(cl), .lap_i(lp),
    .down_i(dn), .load_sec_i(ld), .seven_seg_o(seg1), .dp_o(dp1),
    .anodes_o(an1), .running_o(run1), .expired_o(exp1), .lap_active_o(lap1));

  stopwatch_mux #(.TICK_DIV(TD), .SCAN_DIV(SD), .SEC_MAX(1)) dut_wrap (
    .clk(clk), .reset_ni(rst_n), .start_i(st2), .clear_i(1'b0), .lap_i(1'b0),
    .down_i(1'b0), .load_sec_i(7'd0), .seven_seg_o(seg2), .dp_o(dp2),
    .anodes_o(an2), .running_o(run2), .expired_o(exp2), .lap_active_o(lap2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (exp1 === 1'b1) begin
      exp_cnt  <= exp_cnt + 1;
      last_exp <= cyc;
    end
    if (exp2 === 1'b1) exp2_cnt <= exp2_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int dec7(input logic [6:0] s);
    case (s)
      7'b1000000: return 0;
      7'b1111001: return 1;
      7'b0100100: return 2;
      7'b0110000: return 3;
      7'b0011001: return 4;
      7'b0010010: return 5;
      7'b0000010: return 6;
      7'b1111000: return 7;
      7'b0000000: return 8;
      7'b0010000: return 9;
      default:    return -1;
    endcase
  endfunction

  // Scan the display until all four digits are seen; -1 on bad code, dp or timeout.
  task automatic read_disp(input int which, output int val);
    int d[4];
    int n, idx, dg;
    bit ok;
    logic [3:0] a;
    logic [6:0] s;
    logic p;
    n = 0; ok = 1;
    for (int i = 0; i < 4; i++) d[i] = -1;
    for (int c = 0; c < 48 && n < 4; c++) begin
      @(negedge clk);
      a = which ? an2 : an1;
      s = which ? seg2 : seg1;
      p = which ? dp2 : dp1;
      case (a)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) ok = 0;
      else begin
        dg = dec7(s);
        if (dg < 0) ok = 0;
        if (d[idx] < 0) begin d[idx] = dg; n++; end
        if (p !== ((idx == 2) ? 1'b0 : 1'b1)) ok = 0;
      end
    end
    val = (ok && n == 4) ? d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0] : -1;
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // m = {start2, lap, clear, start}; called at a negedge, returns the cycle of the rise.
  task automatic press(input logic [3:0] m, output int k);
    if (m[0]) st = 1;
    if (m[1]) cl = 1;
    if (m[2]) lp = 1;
    if (m[3]) st2 = 1;
    k = cyc;
    repeat (4) @(negedge clk);
    st = 0; cl = 0; lp = 0; st2 = 0;
  endtask

  initial begin
    int k, r, len, v, adv, L, e0, n, prev;
    int seq[4];
    bit dpok;

    repeat (3) @(negedge clk);
    chk("rst_anodes", an1, 4'b1110);
    chk("rst_seg", seg1, 7'b1000000);
    chk("rst_dp", dp1, 1'b1);
    chk("rst_running", run1, 1'b0);
    chk("rst_expired", exp1, 1'b0);
    chk("rst_lap", lap1, 1'b0);
    rst_n = 1;
    repeat (3) @(negedge clk);

    // wrap with SEC_MAX = 1
    press(4'b1000, k);
    at_cyc(k + 790);
    chk("wrap_running", run2, 1'b1);
    at_cyc(k + 800);
    press(4'b1000, r);
    read_disp(1, v);
    chk("wrap_count", v, 0);
    chk("wrap_paused", run2, 1'b0);
    adv = 800;
    len = $urandom_range(20, 700);
    press(4'b1000, r);
    at_cyc(r + len);
    press(4'b1000, k);
    adv += len;
    read_disp(1, v);
    chk("wrap_rand", v, (adv / TD) % 200);
    chk("wrap_noexp", exp2_cnt, 0);

    // up-count
    press(4'b0001, k);
    at_cyc(k + 400);
    chk("up_running", run1, 1'b1);
    press(4'b0001, r);
    read_disp(0, v);
    chk("up_0100", v, 100);
    adv = 400;
    for (int i = 0; i < 3; i++) begin
      len = $urandom_range(8, 900);
      press(4'b0001, r);
      at_cyc(r + len);
      press(4'b0001, k);
      adv += len;
      read_disp(0, v);
      chk("up_rand", v, (adv / TD) % 6000);
    end

    // clear, pause at 00.37 and hold
    press(4'b0010, k);
    chk("clr_running", run1, 1'b0);
    read_disp(0, v);
    chk("clr_zero", v, 0);
    press(4'b0001, k);
    at_cyc(k + 148);
    press(4'b0001, r);
    read_disp(0, v);
    chk("pause_37", v, 37);
    repeat (100) @(negedge clk);
    read_disp(0, v);
    chk("pause_hold", v, 37);

    // clear and start together; divider must restart from zero
    press(4'b0001, k);
    at_cyc(k + 60);
    press(4'b0011, r);
    repeat (2) @(negedge clk);
    chk("prio_idle", run1, 1'b0);
    read_disp(0, v);
    chk("prio_zero", v, 0);
    press(4'b0001, k);
    at_cyc(k + 10);
    press(4'b0001, r);
    read_disp(0, v);
    chk("div_cleared", v, 2);

    // preload clamp
    dn = 1; ld = 7'd99;
    press(4'b0010, k);
    read_disp(0, v);
    chk("clamp_99", v, 5900);
    ld = 7'($urandom_range(0, 127));
    press(4'b0010, k);
    read_disp(0, v);
    chk("clamp_rand", v, ((ld > 59) ? 59 : int'(ld)) * 100);

    // countdown to expiry
    ld = 7'd2;
    press(4'b0010, k);
    read_disp(0, v);
    chk("cd_load", v, 200);
    e0 = exp_cnt;
    press(4'b0001, k);
    at_cyc(k + 795);
    chk("cd_running", run1, 1'b1);
    chk("cd_noexp_yet", exp_cnt - e0, 0);
    at_cyc(k + 810);
    chk("cd_pulse_once", exp_cnt - e0, 1);
    chk("cd_pulse_cycle", last_exp, k + 803);
    chk("cd_stopped", run1, 1'b0);
    read_disp(0, v);
    chk("cd_zero", v, 0);
    press(4'b0001, r);
    repeat (2) @(negedge clk);
    chk("exp_start_ign", run1, 1'b0);
    chk("exp_no_repulse", exp_cnt - e0, 1);

    // random countdown with down_i flipped after start (mode frozen)
    L = $urandom_range(1, 5);
    ld = 7'(L);
    press(4'b0010, k);
    press(4'b0001, k);
    dn = 0;
    len = $urandom_range(10, L * 400 - 20);
    at_cyc(k + len);
    press(4'b0001, r);
    read_disp(0, v);
    chk("cd_rand", v, L * 100 - len / TD);
    dn = 1;

    // countdown started at 00.00
    ld = 7'd0;
    press(4'b0010, k);
    e0 = exp_cnt;
    press(4'b0001, k);
    repeat (2) @(negedge clk);
    chk("zero_start_pulse", exp_cnt - e0, 1);
    chk("zero_start_cycle", last_exp, k + 3);
    chk("zero_start_norun", run1, 1'b0);

    dn = 0;
    press(4'b0010, k);
`ifdef STOPWATCH_LAP_EN
    press(4'b0001, k);
    at_cyc(k + 41);
    press(4'b0100, r);
    @(negedge clk);
    chk("lap_on", lap1, 1'b1);
    read_disp(0, v);
    chk("lap_frozen", v, 10);
    at_cyc(k + 75);
    press(4'b0100, r);
    at_cyc(k + 81);
    press(4'b0001, r);
    chk("lap_off", lap1, 1'b0);
    read_disp(0, v);
    chk("lap_live", v, 20);
    press(4'b0100, r);
    chk("lap_pause_ign", lap1, 1'b0);
    press(4'b0001, k);
    press(4'b0100, r);
    chk("lap_on2", lap1, 1'b1);
    press(4'b0010, r);
    chk("lap_clr_rel", lap1, 1'b0);
`else
    press(4'b0001, k);
    press(4'b0100, r);
    repeat (2) @(negedge clk);
    chk("lap_disabled", lap1, 1'b0);
    press(4'b0010, r);
`endif

    // reset mid-run, then scan order
    press(4'b0001, k);
`ifdef STOPWATCH_LAP_EN
    press(4'b0100, r);
`endif
    at_cyc(k + 40);
    chk("pre_rst_run", run1, 1'b1);
    e0 = exp_cnt;
    rst_n = 0;
    #1;
    chk("arst_anodes", an1, 4'b1110);
    chk("arst_seg", seg1, 7'b1000000);
    chk("arst_dp", dp1, 1'b1);
    chk("arst_running", run1, 1'b0);
    chk("arst_lap", lap1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    n = 0; prev = -1; dpok = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (int'(an1) != prev && n < 4) begin seq[n] = int'(an1); n++; end
      prev = int'(an1);
      if (dp1 !== ((an1 == 4'b1011) ? 1'b0 : 1'b1)) dpok = 0;
    end
    chk("scan_0", seq[0], 4'b1110);
    chk("scan_1", seq[1], 4'b1101);
    chk("scan_2", seq[2], 4'b1011);
    chk("scan_3", seq[3], 4'b0111);
    chk("scan_dp", dpok, 1'b1);
    chk("rst_no_pulse", exp_cnt - e0, 0);
    read_disp(0, v);
    chk("rst_count", v, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
